// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register.
// Carries a control bundle, NUM_DATA data lanes and a destination register
// index between two CPU pipeline stages. It uses a valid/ready handshake,
// supports a synchronous flush for bubble insertion, and can optionally add
// a two-entry skid buffer so that ready_o comes straight from a flop.
//
// Handshake contract:
//   A beat moves upstream -> stage when valid_i & ready_o & ~flush_i at a
//   rising clk_i edge.
//   A beat moves stage -> downstream when valid_o & ready_i at a rising edge.
//   Once valid_o is high, the stage holds it high with stable ctrl_o, data_o
//   and rd_o until the beat is taken or flushed.
//   An upstream beat that is not accepted must be held by the producer.
//
// State encoding matches count_o, so the FSM state can be observed directly
// on that port: EMPTY=0, FULL=1 (only M valid), SKID=2 (M and S valid).
module pipe_stage_reg #(
   parameter int CTRL_W   = 4,
   parameter int DATA_W   = 32,
   parameter int NUM_DATA = 2,
   parameter int RD_W     = 5,
   parameter int SKID     = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [CTRL_W-1:0]          ctrl_i,
   input  logic [NUM_DATA*DATA_W-1:0] data_i,
   input  logic [RD_W-1:0]            rd_i,
   input  logic                       flush_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [CTRL_W-1:0]          ctrl_o,
   output logic [NUM_DATA*DATA_W-1:0] data_o,
   output logic [RD_W-1:0]            rd_o,
   output logic [1:0]                 count_o
);

   localparam int LANES_W = NUM_DATA * DATA_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_ready;

   // Main entry M drives the outputs; skid entry S holds the overflow beat.
   logic [CTRL_W-1:0]   r_m_ctrl;
   logic [LANES_W-1:0]  r_m_data;
   logic [RD_W-1:0]     r_m_rd;
   logic [CTRL_W-1:0]   r_s_ctrl;
   logic [LANES_W-1:0]  r_s_data;
   logic [RD_W-1:0]     r_s_rd;

   logic                w_in_fire;
   logic                w_out_fire;
   logic                w_load_m_in;
   logic                w_load_m_s;
   logic                w_load_s;

   // Handshake qualifiers; flush suppresses acceptance of the presented beat.
   assign valid_o    = (r_state != ST_EMPTY);
   assign w_in_fire  = valid_i & ready_o & ~flush_i;
   assign w_out_fire = valid_o & ready_i;

   // With the skid buffer, ready_o comes from a flop and never from ready_i.
   // Without it, the stage can accept whenever its single entry is free or
   // is being drained in the same cycle.
   generate
      if (SKID != 0) begin : g_ready_reg
         assign ready_o = r_ready;
      end else begin : g_ready_comb
         assign ready_o = ~valid_o | ready_i;
      end
   endgenerate

   // An invalid stage must never present write enables downstream.
   assign ctrl_o  = valid_o ? r_m_ctrl : '0;
   assign data_o  = r_m_data;
   assign rd_o    = r_m_rd;
   assign count_o = r_state;

   // Next-state and entry-load decode; flush overrides every other event.
   always_comb begin
      w_state_nxt = r_state;
      w_load_m_in = 1'b0;
      w_load_m_s  = 1'b0;
      w_load_s    = 1'b0;
      if (flush_i) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt = ST_FULL;
                  w_load_m_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (w_in_fire && w_out_fire) begin
                  w_state_nxt = ST_FULL;
                  w_load_m_in = 1'b1;
               end else if (w_in_fire) begin
                  // Only reachable with the skid buffer: without it, a full
                  // stage accepts only while ready_i drains M this cycle.
                  if (SKID != 0) begin
                     w_state_nxt = ST_SKID;
                     w_load_s    = 1'b1;
                  end
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               // S is older than anything upstream, so it always refills M
               // before a new beat can enter.
               if (w_out_fire) begin
                  w_state_nxt = ST_FULL;
                  w_load_m_s  = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_EMPTY;
            end
         endcase
      end
   end

   // State register plus registered ready, which is high unless S is occupied.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_EMPTY;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt != ST_SKID);
      end
   end

   // Payload storage; flush leaves the payload in place because the
   // cleared state already hides it behind valid_o.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_m_ctrl <= '0;
         r_m_data <= '0;
         r_m_rd   <= '0;
         r_s_ctrl <= '0;
         r_s_data <= '0;
         r_s_rd   <= '0;
      end else begin
         if (w_load_m_in) begin
            r_m_ctrl <= ctrl_i;
            r_m_data <= data_i;
            r_m_rd   <= rd_i;
         end else if (w_load_m_s) begin
            r_m_ctrl <= r_s_ctrl;
            r_m_data <= r_s_data;
            r_m_rd   <= r_s_rd;
         end
         if (w_load_s) begin
            r_s_ctrl <= ctrl_i;
            r_s_data <= data_i;
            r_s_rd   <= rd_i;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default build (skid buffer), a
// single-entry build and a wide build, all sharing one clock and reset.
module tb_pipe_stage_reg;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // ---------------- default build (SKID=1) ----------------
   logic        valid_i, ready_o, flush_i, valid_o, ready_i;
   logic [3:0]  ctrl_i, ctrl_o;
   logic [63:0] data_i, data_o;
   logic [4:0]  rd_i, rd_o;
   logic [1:0]  count_o;

   pipe_stage_reg u_dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .ctrl_i  (ctrl_i),
      .data_i  (data_i),
      .rd_i    (rd_i),
      .flush_i (flush_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .ctrl_o  (ctrl_o),
      .data_o  (data_o),
      .rd_o    (rd_o),
      .count_o (count_o)
   );

   // ---------------- single-entry build (SKID=0) ----------------
   logic        s0_valid_i, s0_ready_o, s0_flush_i, s0_valid_o, s0_ready_i;
   logic [3:0]  s0_ctrl_i, s0_ctrl_o;
   logic [63:0] s0_data_i, s0_data_o;
   logic [4:0]  s0_rd_i, s0_rd_o;
   logic [1:0]  s0_count_o;

   pipe_stage_reg #(.SKID(0)) u_dut_s0 (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (s0_valid_i),
      .ready_o (s0_ready_o),
      .ctrl_i  (s0_ctrl_i),
      .data_i  (s0_data_i),
      .rd_i    (s0_rd_i),
      .flush_i (s0_flush_i),
      .valid_o (s0_valid_o),
      .ready_i (s0_ready_i),
      .ctrl_o  (s0_ctrl_o),
      .data_o  (s0_data_o),
      .rd_o    (s0_rd_o),
      .count_o (s0_count_o)
   );

   // ---------------- wide build ----------------
   logic         w_valid_i, w_ready_o, w_flush_i, w_valid_o, w_ready_i;
   logic [1:0]   w_ctrl_i, w_ctrl_o;
   logic [191:0] w_data_i, w_data_o;
   logic [5:0]   w_rd_i, w_rd_o;
   logic [1:0]   w_count_o;

   pipe_stage_reg #(.CTRL_W(2), .DATA_W(64), .NUM_DATA(3), .RD_W(6)) u_dut_w (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (w_valid_i),
      .ready_o (w_ready_o),
      .ctrl_i  (w_ctrl_i),
      .data_i  (w_data_i),
      .rd_i    (w_rd_i),
      .flush_i (w_flush_i),
      .valid_o (w_valid_o),
      .ready_i (w_ready_i),
      .ctrl_o  (w_ctrl_o),
      .data_o  (w_data_o),
      .rd_o    (w_rd_o),
      .count_o (w_count_o)
   );

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      valid_i = 0; ctrl_i = 0; data_i = 0; rd_i = 0; flush_i = 0; ready_i = 1;
      s0_valid_i = 0; s0_ctrl_i = 0; s0_data_i = 0; s0_rd_i = 0; s0_flush_i = 0; s0_ready_i = 0;
      w_valid_i = 0; w_ctrl_i = 0; w_data_i = 0; w_rd_i = 0; w_flush_i = 0; w_ready_i = 1;
      #1 rst_n = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_valid", valid_o, 0);
      check("rst_ctrl", ctrl_o, 0);
      check("rst_data", data_o, 0);
      check("rst_rd", rd_o, 0);
      check("rst_count", count_o, 0);
      check("rst_ready", ready_o, 1);
      check("rst_s0_ready", s0_ready_o, 1);
      check("rst_w_valid", w_valid_o, 0);
      rst_n = 1'b1;

      // reset mid-stream
      valid_i = 1; ctrl_i = 4'hF; data_i = {32'hDEAD_BEEF, 32'h1234_5678}; rd_i = 5'd3; ready_i = 1;
      tick();
      check("mid_pre_valid", valid_o, 1);
      check("mid_pre_rd", rd_o, 5'd3);
      check("mid_pre_ctrl", ctrl_o, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_ctrl", ctrl_o, 0);
      check("mid_rst_data", data_o, 0);
      check("mid_rst_rd", rd_o, 0);
      check("mid_rst_count", count_o, 0);
      check("mid_rst_ready", ready_o, 1);
      #1 rst_n = 1'b1;
      #1;
      check("mid_rel_valid", valid_o, 0);
      tick();
      check("mid_first_valid", valid_o, 1);
      check("mid_first_rd", rd_o, 5'd3);
      check("mid_first_data", data_o, {32'hDEAD_BEEF, 32'h1234_5678});
      valid_i = 0;
      tick();
      check("mid_drain_valid", valid_o, 0);
      check("mid_drain_ctrl", ctrl_o, 0);

      // streaming, ready_i held high
      ctrl_i = 4'h5;
      for (int i = 1; i <= 8; i++) begin
         valid_i = 1; rd_i = 5'(i); data_i = {32'h0, 32'(i)};
         tick();
         check("stream_valid", valid_o, 1);
         check("stream_rd", rd_o, 5'(i));
         check("stream_lane0", data_o[31:0], 32'(i));
         check("stream_count", count_o, 2'd1);
      end
      valid_i = 0;
      tick();
      check("stream_end_valid", valid_o, 0);
      check("stream_end_count", count_o, 0);

      // backpressure into the skid entry
      valid_i = 1; rd_i = 5'd1;
      tick();
      check("bp_e1_rd", rd_o, 5'd1);
      ready_i = 0; rd_i = 5'd2;
      tick();
      check("bp_e2_count", count_o, 2'd2);
      check("bp_e2_ready", ready_o, 0);
      check("bp_e2_rd", rd_o, 5'd1);
      rd_i = 5'd3;
      tick();
      check("bp_e3_count", count_o, 2'd2);
      check("bp_e3_rd", rd_o, 5'd1);
      tick();
      check("bp_e4_count", count_o, 2'd2);
      check("bp_e4_ready", ready_o, 0);
      ready_i = 1;
      tick();
      check("bp_e5_rd", rd_o, 5'd2);
      check("bp_e5_count", count_o, 2'd1);
      check("bp_e5_ready", ready_o, 1);
      tick();
      check("bp_e6_rd", rd_o, 5'd3);
      rd_i = 5'd4;
      tick();
      check("bp_e7_rd", rd_o, 5'd4);
      check("bp_e7_valid", valid_o, 1);
      valid_i = 0;
      tick();
      check("bp_e8_valid", valid_o, 0);

      // flush with two beats held and a third presented
      ready_i = 0; valid_i = 1; rd_i = 5'd5;
      tick();
      rd_i = 5'd6;
      tick();
      check("fl_pre_count", count_o, 2'd2);
      flush_i = 1; rd_i = 5'd7;
      tick();
      check("fl_valid", valid_o, 0);
      check("fl_ctrl", ctrl_o, 0);
      check("fl_count", count_o, 0);
      check("fl_ready", ready_o, 1);
      flush_i = 0; ready_i = 1; rd_i = 5'd8;
      tick();
      check("fl_next_valid", valid_o, 1);
      check("fl_next_rd", rd_o, 5'd8);
      check("fl_next_count", count_o, 2'd1);
      flush_i = 1; rd_i = 5'd9;
      tick();
      check("fl_drop_valid", valid_o, 0);
      check("fl_drop_count", count_o, 0);
      flush_i = 0; valid_i = 0;
      tick();
      check("fl_idle_valid", valid_o, 0);

      // single-entry build: combinational ready_o
      s0_ready_i = 0; s0_valid_i = 1; s0_rd_i = 5'd1; s0_ctrl_i = 4'h3;
      #1;
      check("s0_empty_ready", s0_ready_o, 1);
      tick();
      check("s0_e1_valid", s0_valid_o, 1);
      check("s0_e1_rd", s0_rd_o, 5'd1);
      check("s0_e1_ready", s0_ready_o, 0);
      s0_rd_i = 5'd2;
      tick();
      check("s0_hold_rd", s0_rd_o, 5'd1);
      check("s0_hold_count", s0_count_o, 2'd1);
      s0_ready_i = 1;
      #1;
      check("s0_comb_ready", s0_ready_o, 1);
      tick();
      check("s0_reload_rd", s0_rd_o, 5'd2);
      check("s0_reload_count", s0_count_o, 2'd1);
      check("s0_reload_ctrl", s0_ctrl_o, 4'h3);
      s0_valid_i = 0;
      tick();
      check("s0_drain_valid", s0_valid_o, 0);
      check("s0_drain_count", s0_count_o, 0);

      // wide build: lane placement
      w_valid_i = 1; w_ctrl_i = 2'b10; w_rd_i = 6'h2A;
      w_data_i = {64'hFFFF_0000_FFFF_0000, 64'h2222, 64'h1111};
      #1;
      check("w_pre_valid", w_valid_o, 0);
      tick();
      check("w_lane2", w_data_o[191:128], 64'hFFFF_0000_FFFF_0000);
      check("w_lane1", w_data_o[127:64], 64'h2222);
      check("w_lane0", w_data_o[63:0], 64'h1111);
      check("w_rd", w_rd_o, 6'h2A);
      check("w_ctrl", w_ctrl_o, 2'b10);
      w_valid_i = 0; w_data_i = 0;
      tick();
      check("w_idle_valid", w_valid_o, 0);
      check("w_idle_ctrl", w_ctrl_o, 0);
      check("w_idle_lane2", w_data_o[191:128], 64'hFFFF_0000_FFFF_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
